approx_add_sub: RTL and testbench

- Parameterised approximate adder/subtractor on two unsigned W-bit operands; produces a (W+1)-bit result.
- Used in the approximate-arithmetic datapath to trade accuracy in the low bits for area and delay.
- Provides a combinational result plus a registered copy of the same result for pipelined consumers.
- The approximation scheme is the lower-part OR adder (LOA). It is compiled in or out with a macro.

---
 rtl/approx_add_sub.sv | 89 ++++++++
 tb/tb_approx_add_sub.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/approx_add_sub.sv
// approx_add_sub: unsigned W-bit adder/subtractor with a (W+1)-bit result.
//
// Optional lower-part OR adder (LOA) approximation, enabled by defining the
// macro APPROX_LOA_EN. With the macro defined and LPL > 0, the low LPL result
// bits are the bitwise OR of the operands and the upper part is an exact adder
// fed by a single carry guessed from bit LPL-1. Without the macro, or with
// LPL = 0, the datapath is exact and LPL is ignored.
//
// Parameters:
//   W    operand width in bits (W >= 2)
//   LPL  number of approximated LSBs (0 <= LPL <= W-1)
//
// Ports:
//   clk      system clock, rising-edge active
//   rst_n    asynchronous active-low reset (clears res_q only)
//   add_sub  0 = in1 + in2, 1 = in1 - in2
//   in1      operand A, unsigned
//   in2      operand B, unsigned
//   res      combinational result, W+1 bits
//   res_q    res registered on the rising edge of clk

module approx_add_sub #(
  parameter int unsigned W   = 13,
  parameter int unsigned LPL = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         add_sub,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  output logic [W:0]   res,
  output logic [W:0]   res_q
);

  // Elaboration-time parameter sanity checks.
  if (W < 2) begin : g_bad_w
    $error("approx_add_sub: W must be at least 2");
  end
  if (LPL > W - 1) begin : g_bad_lpl
    $error("approx_add_sub: LPL must not exceed W-1");
  end

  // Subtraction is in1 + ~in2 + 1; the +1 is the add_sub carry-in on the
  // exact path.
  logic [W-1:0] b;
  logic [W-1:0] sum;
  logic         cout;

  assign b = add_sub ? ~in2 : in2;

`ifdef APPROX_LOA_EN
  if (LPL > 0) begin : g_loa
    logic [W-LPL:0] upper;
    logic           c;

    // Carry into the exact upper part is predicted from the top approximated
    // bit only; the subtract carry-in is deliberately dropped.
    assign c     = in1[LPL-1] & b[LPL-1];
    assign upper = {1'b0, in1[W-1:LPL]} + {1'b0, b[W-1:LPL]} + {{(W-LPL){1'b0}}, c};
    assign sum   = {upper[W-LPL-1:0], in1[LPL-1:0] | b[LPL-1:0]};
    assign cout  = upper[W-LPL];
  end else begin : g_exact
    logic [W:0] full;

    assign full = {1'b0, in1} + {1'b0, b} + {{W{1'b0}}, add_sub};
    assign sum  = full[W-1:0];
    assign cout = full[W];
  end
`else
  logic [W:0] full;

  assign full = {1'b0, in1} + {1'b0, b} + {{W{1'b0}}, add_sub};
  assign sum  = full[W-1:0];
  assign cout = full[W];
`endif

  // For subtraction the inverted carry is the sign bit of the W+1-bit
  // two's-complement difference.
  assign res = {add_sub ? ~cout : cout, sum};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
    end else begin
      res_q <= res;
    end
  end

endmodule

// File: tb/tb_approx_add_sub.sv
// Directed, table-driven bench for approx_add_sub at W=13, LPL=4.
// Each vector carries hand-computed results for both the exact build and the
// APPROX_LOA_EN build; the one matching the compile-time macro is used.

module tb_approx_add_sub;

  localparam int unsigned W   = 13;
  localparam int unsigned LPL = 4;

  logic         clk;
  logic         rst_n;
  logic         add_sub;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic [W:0]   res;
  logic [W:0]   res_q;

  int n_cmp;
  int n_bad;

  approx_add_sub #(
    .W  (W),
    .LPL(LPL)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .add_sub(add_sub),
    .in1    (in1),
    .in2    (in2),
    .res    (res),
    .res_q  (res_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    string        name;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   exp_exact;
    logic [W:0]   exp_loa;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string nm, input logic [W:0] act, input logic [W:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
    end
  endtask

  function automatic logic [W:0] pick(input vec_t v);
`ifdef APPROX_LOA_EN
    return v.exp_loa;
`else
    return v.exp_exact;
`endif
  endfunction

  task automatic drive(input vec_t v);
    add_sub = v.op;
    in1     = v.a;
    in2     = v.b;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    //           name           op    a         b         exact      loa
    vecs[0]  = '{"add_100_200", 1'b0, 13'h0064, 13'h00C8, 14'h012C, 14'h012C};
    vecs[1]  = '{"sub_5_3",     1'b1, 13'h0005, 13'h0003, 14'h0002, 14'h3FFD};
    vecs[2]  = '{"sub_3_5",     1'b1, 13'h0003, 13'h0005, 14'h3FFE, 14'h3FFB};
    vecs[3]  = '{"add_max_max", 1'b0, 13'h1FFF, 13'h1FFF, 14'h3FFE, 14'h3FFF};
    vecs[4]  = '{"add_f_1",     1'b0, 13'h000F, 13'h0001, 14'h0010, 14'h000F};
    vecs[5]  = '{"sub_10_1",    1'b1, 13'h0010, 13'h0001, 14'h000F, 14'h000E};
    vecs[6]  = '{"sub_equal",   1'b1, 13'h0ABC, 13'h0ABC, 14'h0000, 14'h3FFF};
    vecs[7]  = '{"add_zero",    1'b0, 13'h0000, 13'h0000, 14'h0000, 14'h0000};
    vecs[8]  = '{"sub_0_max",   1'b1, 13'h0000, 13'h1FFF, 14'h2001, 14'h2000};
    vecs[9]  = '{"sub_max_0",   1'b1, 13'h1FFF, 13'h0000, 14'h1FFF, 14'h1FFF};
    vecs[10] = '{"add_mixed",   1'b0, 13'h1234, 13'h0567, 14'h179B, 14'h1797};
    vecs[11] = '{"sub_borrow",  1'b1, 13'h1000, 13'h0FFF, 14'h0001, 14'h0000};

    // Reset state.
    rst_n = 1'b0;
    drive(vecs[0]);
    #1;
    check("reset_res_q", res_q, '0);
    check("reset_res_comb", res, pick(vecs[0]));
    @(negedge clk);
    rst_n = 1'b1;

    // Main table: combinational result, then registered copy one edge later.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check({vecs[i].name, "_res"}, res, pick(vecs[i]));
      @(posedge clk);
      #1;
      check({vecs[i].name, "_res_q"}, res_q, pick(vecs[i]));
    end

    // Mid-cycle asynchronous reset.
    @(negedge clk);
    drive(vecs[0]);
    @(posedge clk);
    #1;
    check("pre_reset_res_q", res_q, pick(vecs[0]));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear_res_q", res_q, '0);
    check("async_res_unaffected", res, pick(vecs[0]));
    drive(vecs[1]);
    #1;
    check("in_reset_res_tracks", res, pick(vecs[1]));
    @(posedge clk);
    #1;
    check("in_reset_res_q_held", res_q, '0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("release_res_q_still_0", res_q, '0);
    @(posedge clk);
    #1;
    check("release_first_capture", res_q, pick(vecs[1]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
